blake512_round_seq: RTL and testbench
=====================================

BLAKE512_ROUND_SEQ -- requirements
Module: blake512_round_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clk and rst_n are named as the codebase does.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1: synchronous active-low reset.
REQ-004 Port start, input, 1: request to begin a 16-round compression.
REQ-005 Port v_in, input, 1024: initialized state v0..v15, v0 at [63:0].
REQ-006 Port m_in, input, 1024: message block m0..m15, m0 at [63:0].
REQ-007 Port busy, output, 1: high while rounds are executing.
REQ-008 Port done, output, 1: one-cycle pulse when v_out is final.
REQ-009 Port v_out, output, 1024: live working state v0..v15, same packing as v_in.

Function
REQ-010 FSM states SHALL be IDLE and RUN; reset state is IDLE.
REQ-011 In IDLE, start=1 SHALL load v_in into the state registers and m_in into the message registers, clear round=0 and gidx=0, and enter RUN on the next edge.
REQ-012 In RUN, each cycle SHALL perform exactly one G evaluation through a single shared G instance and write back the four updated words on the clock edge.
REQ-013 The gidx→(a,b,c,d) word mapping SHALL be: 0:(0,4,8,12), 1:(1,5,9,13), 2:(2,6,10,14), 3:(3,7,11,15), 4:(0,5,10,15), 5:(1,6,11,12), 6:(2,7,8,13), 7:(3,4,9,14).
REQ-014 G inputs SHALL be s=SIGMA[round mod 10], msg_j=m[s[2*gidx]], msg_k=m[s[2*gidx+1]], C64_j=C[s[2*gidx]], C64_k=C[s[2*gidx+1]].
REQ-015 gidx SHALL be a 3-bit counter that increments every RUN cycle; on wrap 7→0, round increments.
REQ-016 round SHALL be a 4-bit counter over 0..15; the mod-10 SIGMA selection SHALL reuse SIGMA rows 0..5 in rounds 10..15.
REQ-017 After the RUN cycle with round=15 and gidx=7, the FSM SHALL return to IDLE and assert done for exactly that next cycle. Total: 128 RUN cycles; done occurs 129 cycles after the start-sampling edge.
REQ-018 busy SHALL equal (state==RUN).
REQ-019 start while in RUN SHALL be ignored. m_in/v_in changes during RUN SHALL have no effect.
REQ-020 start in the same cycle that done is high (IDLE) SHALL be accepted normally, giving back-to-back operation.
REQ-021 v_out SHALL hold its final value in IDLE until the next accepted start.
REQ-022 All additions SHALL be modulo 2^64. Rotations and the XOR pairing are owned by the G sub-module.

Reset
REQ-023 rst_n=0 on a clock edge SHALL force IDLE, round=0, gidx=0, busy=0, done=0, and all state and message registers to 0, so v_out=0.
REQ-024 Reset mid-RUN SHALL abort the compression with no done pulse; the next start after reset behaves as a fresh start.

Structure
REQ-025 Package blake512_pkg SHALL hold the 10x16 SIGMA table (4-bit entries), the 16 C64 constants, the FSM state enum, and the G word-index table.
REQ-026 The block SHALL instantiate exactly one existing blake512_G_func as its only sub-module (purely combinational, ports a,b,c,d,msg_j,msg_k,C64_j,C64_k → a_out..d_out); no second G instance.

Verification
REQ-027 First G: v_in with v0=6a09e667f3bcc908, v4=510e527fade682d1, v8=243f6a8885a308d3, v12=452821e638d011f7, m0=00000020b7f3f008, m1=aafa9c96f2018962, others 0, plus start → after the first RUN edge: v0=0a2c5275e9d6e334, v4=9d87cdc6ea902d3b, v8=935aae359d644eb2, v12=002464da8ca762cf; all other words unchanged.
REQ-028 Timing: start pulse → busy high for exactly 128 cycles, done high for 1 cycle at cycle 129, busy low with done.
REQ-029 Full compression: random v_in/m_in (≥20 vectors) → v_out at done matches the software BLAKE-512 16-round model bit-exactly, covering the rounds 10..15 SIGMA reuse.
REQ-030 start held high continuously → back-to-back compressions with exactly 129-cycle done spacing; start pulses during RUN cause no restart.
REQ-031 rst_n low at round=7/gidx=3 → next cycle busy=0, done=0, v_out=0; no done follows; a subsequent start completes with the correct result.

Source files
------------

// File: rtl/blake512_pkg.sv
// Shared BLAKE-512 tables and helpers: message permutation rows, pi-derived
// constants, G word-index mapping and the round-sequencer state type.
package blake512_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] d;
    } gword_t;

    localparam logic [3:0] LAST_ROUND = 4'd15;
    localparam logic [2:0] LAST_GIDX  = 3'd7;

    // Each row packs 16 nibbles, entry i at bits [4i+3:4i].
    function automatic logic [63:0] sigma_row(input logic [3:0] row);
        logic [63:0] r;
        case (row)
            4'd0:    r = 64'hFEDCBA9876543210;
            4'd1:    r = 64'h357B20C16DF984AE;
            4'd2:    r = 64'h491763EADF250C8B;
            4'd3:    r = 64'h8F04A562EBCD1397;
            4'd4:    r = 64'hD386CB1EFA427509;
            4'd5:    r = 64'h91EF57D438B0A6C2;
            4'd6:    r = 64'hB8293670A4DEF15C;
            4'd7:    r = 64'hA2684F05931CE7BD;
            4'd8:    r = 64'h5A417D2C803B9EF6;
            4'd9:    r = 64'h0DC3E9BF5167482A;
            default: r = 64'hFEDCBA9876543210;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sigma_at(input logic [3:0] row, input logic [3:0] idx);
        logic [63:0] r;
        r = sigma_row(row);
        return r[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] c64(input logic [3:0] idx);
        logic [63:0] c;
        case (idx)
            4'd0:    c = 64'h243F6A8885A308D3;
            4'd1:    c = 64'h13198A2E03707344;
            4'd2:    c = 64'hA4093822299F31D0;
            4'd3:    c = 64'h082EFA98EC4E6C89;
            4'd4:    c = 64'h452821E638D01377;
            4'd5:    c = 64'hBE5466CF34E90C6C;
            4'd6:    c = 64'hC0AC29B7C97C50DD;
            4'd7:    c = 64'h3F84D5B5B5470917;
            4'd8:    c = 64'h9216D5D98979FB1B;
            4'd9:    c = 64'hD1310BA698DFB5AC;
            4'd10:   c = 64'h2FFD72DBD01ADFB7;
            4'd11:   c = 64'hB8E1AFED6A267E96;
            4'd12:   c = 64'hBA7C9045F12C7F99;
            4'd13:   c = 64'h24A19947B3916CF7;
            4'd14:   c = 64'h0801F2E2858EFC16;
            4'd15:   c = 64'h636920D871574E69;
            default: c = 64'h0000000000000000;
        endcase
        return c;
    endfunction

    // Four column steps followed by four diagonal steps.
    function automatic gword_t g_words(input logic [2:0] gidx);
        gword_t w;
        case (gidx)
            3'd0:    w = '{a: 4'd0, b: 4'd4, c: 4'd8,  d: 4'd12};
            3'd1:    w = '{a: 4'd1, b: 4'd5, c: 4'd9,  d: 4'd13};
            3'd2:    w = '{a: 4'd2, b: 4'd6, c: 4'd10, d: 4'd14};
            3'd3:    w = '{a: 4'd3, b: 4'd7, c: 4'd11, d: 4'd15};
            3'd4:    w = '{a: 4'd0, b: 4'd5, c: 4'd10, d: 4'd15};
            3'd5:    w = '{a: 4'd1, b: 4'd6, c: 4'd11, d: 4'd12};
            3'd6:    w = '{a: 4'd2, b: 4'd7, c: 4'd8,  d: 4'd13};
            3'd7:    w = '{a: 4'd3, b: 4'd4, c: 4'd9,  d: 4'd14};
            default: w = '{a: 4'd0, b: 4'd4, c: 4'd8,  d: 4'd12};
        endcase
        return w;
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [6:0] n);
        return (x >> n) | (x << (7'd64 - n));
    endfunction

endpackage

// File: rtl/blake512_round_seq_g.sv
// Combinational BLAKE-512 G function: two add/xor/rotate half-steps on four
// working words, mixing in message words paired with the opposite constant.
module blake512_G_func
    import blake512_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [63:0] c,
    input  logic [63:0] d,
    input  logic [63:0] msg_j,
    input  logic [63:0] msg_k,
    input  logic [63:0] C64_j,
    input  logic [63:0] C64_k,
    output logic [63:0] a_out,
    output logic [63:0] b_out,
    output logic [63:0] c_out,
    output logic [63:0] d_out
);

    logic [63:0] a1_s, b1_s, c1_s, d1_s;

    // First half uses rotations 32/25, second half 16/11.
    always_comb begin
        a1_s  = a + b + (msg_j ^ C64_k);
        d1_s  = rotr64(d ^ a1_s, 7'd32);
        c1_s  = c + d1_s;
        b1_s  = rotr64(b ^ c1_s, 7'd25);
        a_out = a1_s + b1_s + (msg_k ^ C64_j);
        d_out = rotr64(d1_s ^ a_out, 7'd16);
        c_out = c1_s + d_out;
        b_out = rotr64(b1_s ^ c_out, 7'd11);
    end

endmodule

// File: rtl/blake512_round_seq.sv
// Sequential BLAKE-512 round engine: one G evaluation per clock through a
// single shared G datapath, 128 steps for a full 16-round compression.
module blake512_round_seq (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1023:0] v_in,
    input  logic [1023:0] m_in,
    output logic          busy,
    output logic          done,
    output logic [1023:0] v_out
);

    import blake512_pkg::*;

    state_t             state_r, state_nx;
    logic [3:0]         round_r;
    logic [2:0]         gidx_r;
    logic [15:0][63:0]  v_r;
    logic [15:0][63:0]  m_r;
    logic               done_r, done_nx;
    logic               load_s, step_s;

    logic [3:0]         sig_row_s;
    logic [3:0]         j_s, k_s;
    gword_t             words_s;
    logic [63:0]        a_out_s, b_out_s, c_out_s, d_out_s;

    // Rounds 10..15 reuse permutation rows 0..5.
    always_comb begin
        if (round_r >= 4'd10) begin
            sig_row_s = round_r - 4'd10;
        end else begin
            sig_row_s = round_r;
        end
        j_s     = sigma_at(sig_row_s, {gidx_r, 1'b0});
        k_s     = sigma_at(sig_row_s, {gidx_r, 1'b1});
        words_s = g_words(gidx_r);
    end

    blake512_G_func u_g (
        .a     (v_r[words_s.a]),
        .b     (v_r[words_s.b]),
        .c     (v_r[words_s.c]),
        .d     (v_r[words_s.d]),
        .msg_j (m_r[j_s]),
        .msg_k (m_r[k_s]),
        .C64_j (c64(j_s)),
        .C64_k (c64(k_s)),
        .a_out (a_out_s),
        .b_out (b_out_s),
        .c_out (c_out_s),
        .d_out (d_out_s)
    );

    // Next-state and control decode; start is only honoured in IDLE.
    always_comb begin
        state_nx = state_r;
        done_nx  = 1'b0;
        load_s   = 1'b0;
        step_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if ((round_r == LAST_ROUND) && (gidx_r == LAST_GIDX)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            done_r  <= done_nx;
        end
    end

    // Working/message registers and the round/step counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r     <= '0;
            m_r     <= '0;
            round_r <= 4'd0;
            gidx_r  <= 3'd0;
        end else if (load_s) begin
            v_r     <= v_in;
            m_r     <= m_in;
            round_r <= 4'd0;
            gidx_r  <= 3'd0;
        end else if (step_s) begin
            v_r[words_s.a] <= a_out_s;
            v_r[words_s.b] <= b_out_s;
            v_r[words_s.c] <= c_out_s;
            v_r[words_s.d] <= d_out_s;
            gidx_r         <= gidx_r + 3'd1;
            if (gidx_r == LAST_GIDX) begin
                round_r <= round_r + 4'd1;
            end
        end
    end

    assign busy  = (state_r == RUN);
    assign done  = done_r;
    assign v_out = v_r;

endmodule

// File: tb/tb_blake512_round_seq.sv
// Bench for blake512_round_seq: directed vectors, random compressions against
// a straightforward BLAKE-512 round model, back-to-back starts and mid-run reset.
module tb_blake512_round_seq;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1023:0] v_in;
    logic [1023:0] m_in;
    logic          busy;
    logic          done;
    logic [1023:0] v_out;

    int checks = 0;
    int failures = 0;

    int sig_tab [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    logic [63:0] cst [16] = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
    };

    blake512_round_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .v_in  (v_in),
        .m_in  (m_in),
        .busy  (busy),
        .done  (done),
        .v_out (v_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference: 16 rounds, each four column G's then four diagonal G's.
    function automatic logic [1023:0] ref_compress(input logic [1023:0] vin, input logic [1023:0] min);
        logic [63:0] v [16];
        logic [63:0] m [16];
        logic [1023:0] res;
        for (int i = 0; i < 16; i++) begin
            v[i] = vin[64*i +: 64];
            m[i] = min[64*i +: 64];
        end
        for (int r = 0; r < 16; r++) begin
            for (int g = 0; g < 8; g++) begin
                int a, b, c, d, sj, sk;
                if (g < 4) begin
                    a = g; b = g + 4; c = g + 8; d = g + 12;
                end else begin
                    a = g - 4; b = 4 + (g - 3) % 4; c = 8 + (g - 2) % 4; d = 12 + (g - 1) % 4;
                end
                sj = sig_tab[r % 10][2*g];
                sk = sig_tab[r % 10][2*g + 1];
                v[a] = v[a] + v[b] + (m[sj] ^ cst[sk]);
                v[d] = rr(v[d] ^ v[a], 32);
                v[c] = v[c] + v[d];
                v[b] = rr(v[b] ^ v[c], 25);
                v[a] = v[a] + v[b] + (m[sk] ^ cst[sj]);
                v[d] = rr(v[d] ^ v[a], 16);
                v[c] = v[c] + v[d];
                v[b] = rr(v[b] ^ v[c], 11);
            end
        end
        for (int i = 0; i < 16; i++) res[64*i +: 64] = v[i];
        return res;
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] x;
        for (int i = 0; i < 32; i++) x[32*i +: 32] = $urandom;
        return x;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int w;
        w = 0;
        for (int i = 15; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) w = i;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s word%0d observed=%h expected=%h", tag, w, obs[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    // One start pulse, then timing and result checks; optional noise on inputs during RUN.
    task automatic run_one(input logic [1023:0] vv, input logic [1023:0] mm, input bit noise, input string tag);
        logic [1023:0] exp;
        int busy_cnt, done_cyc;
        bit seen;
        exp = ref_compress(vv, mm);
        @(negedge clk);
        v_in = vv; m_in = mm; start = 1'b1;
        busy_cnt = 0; done_cyc = 0; seen = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen; cyc++) begin
            @(negedge clk);
            start = (noise && cyc < 120) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                v_in = rand1024();
                m_in = rand1024();
            end
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
                check_v({tag, "_result"}, v_out, exp);
                check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd128);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'd129);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check_v({tag, "_hold"}, v_out, exp);
    endtask

    initial begin
        logic [1023:0] vv, mm, e1, exp;
        logic [1023:0] exp_q [$];
        int last_done, ndone, dcount;

        rst_n = 1'b0; start = 1'b0; v_in = '0; m_in = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check_v("reset_vout", v_out, '0);
        rst_n = 1'b1;

        // Known first G step.
        vv = '0; mm = '0;
        vv[64*0 +: 64]  = 64'h6a09e667f3bcc908;
        vv[64*4 +: 64]  = 64'h510e527fade682d1;
        vv[64*8 +: 64]  = 64'h243f6a8885a308d3;
        vv[64*12 +: 64] = 64'h452821e638d011f7;
        mm[64*0 +: 64]  = 64'h00000020b7f3f008;
        mm[64*1 +: 64]  = 64'haafa9c96f2018962;
        e1 = vv;
        e1[64*0 +: 64]  = 64'h0a2c5275e9d6e334;
        e1[64*4 +: 64]  = 64'h9d87cdc6ea902d3b;
        e1[64*8 +: 64]  = 64'h935aae359d644eb2;
        e1[64*12 +: 64] = 64'h002464da8ca762cf;
        @(negedge clk);
        v_in = vv; m_in = mm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_v("load_state", v_out, vv);
        check("load_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("g0_v0", v_out[64*0 +: 64], 64'h0a2c5275e9d6e334);
        check("g0_v4", v_out[64*4 +: 64], 64'h9d87cdc6ea902d3b);
        check("g0_v8", v_out[64*8 +: 64], 64'h935aae359d644eb2);
        check("g0_v12", v_out[64*12 +: 64], 64'h002464da8ca762cf);
        check_v("g0_all", v_out, e1);
        dcount = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("g0_done_seen", 64'(dcount), 64'd1);
        check_v("g0_final", v_out, ref_compress(vv, mm));
        @(negedge clk);

        run_one(vv, mm, 1'b0, "known");

        for (int t = 0; t < 20; t++) begin
            run_one(rand1024(), rand1024(), (t % 2) == 1, "rand");
        end

        // start held high: back-to-back runs with new inputs taken at each done.
        @(negedge clk);
        vv = rand1024(); mm = rand1024();
        v_in = vv; m_in = mm; start = 1'b1;
        exp_q.push_back(ref_compress(vv, mm));
        last_done = 0; ndone = 0;
        for (int cyc = 1; cyc <= 600 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                exp = exp_q.pop_front();
                check_v("b2b_result", v_out, exp);
                check("b2b_spacing", 64'(cyc - last_done), 64'd129);
                last_done = cyc;
                if (ndone < 3) begin
                    vv = rand1024(); mm = rand1024();
                    v_in = vv; m_in = mm;
                    exp_q.push_back(ref_compress(vv, mm));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(ndone), 64'd3);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", 64'(busy), 64'd0);

        // Reset at round 7, step 3 aborts the run.
        vv = rand1024(); mm = rand1024();
        v_in = vv; m_in = mm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check_v("midrst_vout", v_out, '0);
        dcount = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("midrst_no_done", 64'(dcount), 64'd0);
        run_one(vv, mm, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
